game_countdown_timer: RTL and testbench
=======================================

Name: game_countdown_timer

Overview:
- Upstream feeder of the game control state machine.
- Generates the free-running one-second tick (OneSecPulse) and runs the round countdown in two BCD digits for the HUD.
- Asserts time_end when the countdown expires.
- Freezes the displayed time once the round is decided (win or lose).

Parameters:
ONE_SEC_CYCLES, 31500000, clk cycles per second tick (bench overrides to a small value)
START_SECONDS, 60, countdown reload value; legal range 1..99
WARN_SECONDS, 10, warning asserted while remaining time <= this value
BONUS_SECONDS, 5, seconds added per bonus pulse (only with the optional feature)

Ports:
clk  input  1  system clock
resetN  input  1  asynchronous active-low reset
GameStart_key  input  1  start request; level or pulse, sampled every cycle
freeze  input  1  round decided (winner_st OR loser_st); level
bonus_pulse  input  1  single-cycle time bonus (ignored unless feature compiled in)
OneSecPulse  output  1  one-cycle tick every ONE_SEC_CYCLES cycles
time_end  output  1  countdown expired; level
secs_tens  output  4  BCD tens digit of remaining seconds
secs_ones  output  4  BCD ones digit of remaining seconds
timer_running  output  1  high in RUN state
warning  output  1  RUN and remaining <= WARN_SECONDS

Behaviour:
- Interface: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values:
  - state IDLE; prescaler counter 0.
  - secs_tens/secs_ones = BCD of START_SECONDS.
  - OneSecPulse, time_end, timer_running and warning all 0.
- Prescaler:
  - Counter runs 0..ONE_SEC_CYCLES-1 in every state, so the downstream state machine can time its end screens.
  - OneSecPulse is registered. It is high for exactly one cycle when the counter wraps.
  - The counter clears to 0 on the IDLE->RUN transition, so the first counted second is full length.
- States: IDLE, RUN, FROZEN, EXPIRED.
  - IDLE: digits hold START_SECONDS. GameStart_key=1 -> RUN next cycle, and the prescaler restarts.
  - RUN:
    - On an internal tick, decrement the BCD value with borrow (ones 0 -> 9, tens-1).
    - Decrement from 01 -> value 00 and state EXPIRED in the same edge.
    - freeze=1 -> FROZEN; freeze has priority over a same-cycle tick, so no decrement happens.
    - GameStart_key is ignored.
  - FROZEN: digits hold. Sticky until reset. Tick and bonus are ignored.
  - EXPIRED:
    - Digits hold 00; time_end=1. Sticky until reset; freeze and start are ignored.
    - time_end first rises the cycle after the tick that reached 00.
- Outputs timer_running, warning and time_end are decoded from the registered state and digits; there is no further latency.
- Digits never go below 00 and never exceed 99.
- Reset mid-operation returns to IDLE with the reload value within the same asynchronous event. No tick is generated during reset.

Optional Feature:
- Macro TIMER_BONUS_EN.
- Defined:
  - In RUN, bonus_pulse adds BONUS_SECONDS using BCD addition with carry, saturating at 99.
  - A bonus coincident with a tick applies net +BONUS_SECONDS-1.
  - A bonus coincident with the 01->00 tick still applies, so the result is BONUS_SECONDS-1 and the timer stays in RUN. If BONUS_SECONDS=1 the result is 00 -> EXPIRED.
  - A bonus coincident with freeze is dropped.
- Undefined: bonus_pulse port remains but is ignored; no adder logic is synthesized.

Decomposition:
- Package game_timer_pkg holds:
  - timer_state_t enum {IDLE, RUN, FROZEN, EXPIRED}.
  - BCD digit typedef (logic [3:0]).
  - Functions bcd_dec2 and bcd_add_sat2 (two-digit BCD decrement and saturating add).
- Sub-module one_sec_pulse_gen: prescaler counter with a sync clear input, producing OneSecPulse. Width is $clog2(ONE_SEC_CYCLES).

Test Plan (ONE_SEC_CYCLES=10, START_SECONDS=3, WARN_SECONDS=2, BONUS_SECONDS=5):
- Reset, idle 35 cycles -> OneSecPulse every 10 cycles; digits 0/3; time_end=0; timer_running=0.
- Start pulse, run 31 cycles:
  - Digits 03->02->01->00 at 10-cycle spacing; warning rises at 02.
  - time_end=1 one cycle after the 00 tick and stays high for 50 more cycles.
- START_SECONDS=20, start, then 1 tick -> digits 1/9 (BCD borrow).
- Start, freeze asserted on the same cycle as the first tick:
  - Digits stay 03; state FROZEN; time_end never asserts.
  - OneSecPulse keeps toggling every 10 cycles.
- TIMER_BONUS_EN:
  - START_SECONDS=97 plus bonus -> 99 (saturated).
  - START_SECONDS=3, bonus coincident with the 01->00 tick -> 04, still running.
- Assert resetN low mid-count at value 01 -> immediate IDLE, digits 03; no time_end; prescaler restarted.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared types and BCD helpers for the game countdown timer.
//   timer_state_t : IDLE / RUN / FROZEN / EXPIRED
//   bcd_digit_t   : one BCD digit
//   bcd2_t        : two-digit BCD value {tens, ones}
//   bin_to_bcd2   : clamp an integer to 0..99 and convert it to two BCD digits
//   bcd2_to_bin   : two BCD digits to a 7-bit binary value
//   bcd_dec2      : two-digit BCD decrement with borrow; 00 stays at 00
//   bcd_add_sat2  : two-digit BCD add with carry; saturates at 99
package game_timer_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FROZEN, EXPIRED} timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd2_t;

  function automatic bcd2_t bin_to_bcd2(input int v);
    int c;
    c = (v > 99) ? 99 : ((v < 0) ? 0 : v);
    bin_to_bcd2.tens = 4'(c / 10);
    bin_to_bcd2.ones = 4'(c % 10);
  endfunction

  function automatic logic [6:0] bcd2_to_bin(input bcd2_t v);
    bcd2_to_bin = ({3'd0, v.tens} * 7'd10) + {3'd0, v.ones};
  endfunction

  function automatic bcd2_t bcd_dec2(input bcd2_t v);
    bcd_dec2 = v;
    if (v.ones != 4'd0) begin
      bcd_dec2.ones = v.ones - 4'd1;
    end else if (v.tens != 4'd0) begin
      bcd_dec2.tens = v.tens - 4'd1;
      bcd_dec2.ones = 4'd9;
    end
  endfunction

  function automatic bcd2_t bcd_add_sat2(input bcd2_t a, input bcd2_t b);
    logic [4:0] os;
    logic [4:0] ts;
    logic       c;
    os = {1'b0, a.ones} + {1'b0, b.ones};
    c  = (os > 5'd9);
    if (c) os = os - 5'd10;
    ts = {1'b0, a.tens} + {1'b0, b.tens} + {4'd0, c};
    if (ts > 5'd9) begin
      bcd_add_sat2.tens = 4'd9;
      bcd_add_sat2.ones = 4'd9;
    end else begin
      bcd_add_sat2.tens = ts[3:0];
      bcd_add_sat2.ones = os[3:0];
    end
  endfunction

endpackage

// File: rtl/game_countdown_timer_one_sec_pulse_gen.sv
// Free-running prescaler producing a registered one-cycle tick.
//   clk    : system clock
//   resetN : asynchronous active-low reset
//   clear  : synchronous restart of the count (tick suppressed that cycle)
//   pulse  : high for one cycle each time the count wraps
module one_sec_pulse_gen #(
  parameter int ONE_SEC_CYCLES = 31500000
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  output logic pulse
);

  localparam int CW = (ONE_SEC_CYCLES > 1) ? $clog2(ONE_SEC_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(ONE_SEC_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (clear) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      pulse <= 1'b1;
    end else begin
      cnt   <= cnt + 1'b1;
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown timer: one-second tick generator plus a two-digit BCD
// countdown that expires into time_end, and freezes once the round is decided.
// Optional feature macro: TIMER_BONUS_EN (bonus_pulse adds BONUS_SECONDS).
//   clk           : system clock
//   resetN        : asynchronous active-low reset
//   GameStart_key : start request, sampled every cycle (acts only in IDLE)
//   freeze        : round decided; moves RUN to FROZEN
//   bonus_pulse   : single-cycle time bonus (ignored without TIMER_BONUS_EN)
//   OneSecPulse   : one-cycle tick every ONE_SEC_CYCLES cycles, in all states
//   time_end      : countdown expired (level)
//   secs_tens     : BCD tens digit of remaining seconds
//   secs_ones     : BCD ones digit of remaining seconds
//   timer_running : high in RUN
//   warning       : RUN and remaining seconds <= WARN_SECONDS
module game_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int ONE_SEC_CYCLES = 31500000,
  parameter int START_SECONDS  = 60,
  parameter int WARN_SECONDS   = 10,
  parameter int BONUS_SECONDS  = 5
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       GameStart_key,
  input  logic       freeze,
  input  logic       bonus_pulse,
  output logic       OneSecPulse,
  output logic       time_end,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic       timer_running,
  output logic       warning
);

  localparam bcd2_t      START_BCD = bin_to_bcd2(START_SECONDS);
  localparam logic [6:0] WARN_BIN  = 7'((WARN_SECONDS > 99) ? 99 :
                                        ((WARN_SECONDS < 0) ? 0 : WARN_SECONDS));
`ifdef TIMER_BONUS_EN
  localparam bcd2_t BONUS_BCD    = bin_to_bcd2(BONUS_SECONDS);
  localparam bcd2_t BONUS_M1_BCD = bin_to_bcd2(BONUS_SECONDS - 1);
`else
  logic unused_bonus;
  assign unused_bonus = bonus_pulse;
`endif

  timer_state_t state, state_nxt;
  bcd2_t        digits, digits_nxt, run_val;
  logic         start_run;
  logic         tick;

  // The prescaler restarts on IDLE->RUN so the first counted second is full.
  assign start_run = (state == IDLE) && GameStart_key;
  assign tick      = OneSecPulse;

  one_sec_pulse_gen #(
    .ONE_SEC_CYCLES(ONE_SEC_CYCLES)
  ) u_pulse (
    .clk   (clk),
    .resetN(resetN),
    .clear (start_run),
    .pulse (OneSecPulse)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state  <= IDLE;
      digits <= START_BCD;
    end else begin
      state  <= state_nxt;
      digits <= digits_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    digits_nxt = digits;
    run_val    = digits;
    case (state)
      IDLE: begin
        digits_nxt = START_BCD;
        if (GameStart_key) state_nxt = RUN;
      end
      RUN: begin
        // freeze wins over a same-cycle tick or bonus: the time shown is final
        if (freeze) begin
          state_nxt = FROZEN;
        end else begin
          run_val = tick ? bcd_dec2(digits) : digits;
`ifdef TIMER_BONUS_EN
          if (bonus_pulse) begin
            // A bonus landing on the expiring 01->00 tick leaves BONUS_SECONDS-1.
            if (tick && (digits == 8'h01)) run_val = BONUS_M1_BCD;
            else                           run_val = bcd_add_sat2(run_val, BONUS_BCD);
          end
`endif
          digits_nxt = run_val;
          if (run_val == 8'h00) state_nxt = EXPIRED;
        end
      end
      FROZEN:  ;
      EXPIRED: digits_nxt = 8'h00;
      default: state_nxt = IDLE;
    endcase
  end

  assign timer_running = (state == RUN);
  assign time_end      = (state == EXPIRED);
  assign warning       = (state == RUN) && (bcd2_to_bin(digits) <= WARN_BIN);
  assign secs_tens     = digits.tens;
  assign secs_ones     = digits.ones;

endmodule

// File: tb/tb_game_countdown_timer.sv
module tb_game_countdown_timer;

  localparam int N    = 10;
  localparam int WARN = 2;
  localparam int BON  = 5;
`ifdef TIMER_BONUS_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_RUN = 1, M_FROZEN = 2, M_EXP = 3;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  logic start = 1'b0;
  logic freeze = 1'b0;
  logic bonus = 1'b0;

  logic [2:0]      p, te, rn, wn;
  logic [2:0][3:0] tens, ones;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: remaining seconds as plain integers
  int m_mode [3];
  int m_rem  [3];
  int m_cnt  [3];
  bit m_pulse[3];
  int starts [3] = '{3, 20, 97};

  always #5 clk = ~clk;

  game_countdown_timer #(.ONE_SEC_CYCLES(N), .START_SECONDS(3), .WARN_SECONDS(WARN),
                         .BONUS_SECONDS(BON)) u_dut0 (
    .clk(clk), .resetN(resetN), .GameStart_key(start), .freeze(freeze), .bonus_pulse(bonus),
    .OneSecPulse(p[0]), .time_end(te[0]), .secs_tens(tens[0]), .secs_ones(ones[0]),
    .timer_running(rn[0]), .warning(wn[0]));

  game_countdown_timer #(.ONE_SEC_CYCLES(N), .START_SECONDS(20), .WARN_SECONDS(WARN),
                         .BONUS_SECONDS(BON)) u_dut1 (
    .clk(clk), .resetN(resetN), .GameStart_key(start), .freeze(freeze), .bonus_pulse(bonus),
    .OneSecPulse(p[1]), .time_end(te[1]), .secs_tens(tens[1]), .secs_ones(ones[1]),
    .timer_running(rn[1]), .warning(wn[1]));

  game_countdown_timer #(.ONE_SEC_CYCLES(N), .START_SECONDS(97), .WARN_SECONDS(WARN),
                         .BONUS_SECONDS(BON)) u_dut2 (
    .clk(clk), .resetN(resetN), .GameStart_key(start), .freeze(freeze), .bonus_pulse(bonus),
    .OneSecPulse(p[2]), .time_end(te[2]), .secs_tens(tens[2]), .secs_ones(ones[2]),
    .timer_running(rn[2]), .warning(wn[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i]  = M_IDLE;
      m_rem[i]   = starts[i];
      m_cnt[i]   = 0;
      m_pulse[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      bit tick;
      int r;
      tick = m_pulse[i];
      if (m_mode[i] == M_IDLE && start) begin
        m_cnt[i] = 0; m_pulse[i] = 1'b0;
      end else if (m_cnt[i] == N - 1) begin
        m_cnt[i] = 0; m_pulse[i] = 1'b1;
      end else begin
        m_cnt[i]++; m_pulse[i] = 1'b0;
      end
      case (m_mode[i])
        M_IDLE: if (start) m_mode[i] = M_RUN;
        M_RUN: begin
          if (freeze) m_mode[i] = M_FROZEN;
          else begin
            r = m_rem[i] - (tick ? 1 : 0);
            if (BEN && bonus)
              r = (tick && m_rem[i] == 1) ? BON - 1 : ((r + BON > 99) ? 99 : r + BON);
            m_rem[i] = r;
            if (r == 0) m_mode[i] = M_EXP;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pulse%0d", i),    8'(p[i]),  8'(m_pulse[i]));
      chk($sformatf("time_end%0d", i), 8'(te[i]), 8'(m_mode[i] == M_EXP));
      chk($sformatf("running%0d", i),  8'(rn[i]), 8'(m_mode[i] == M_RUN));
      chk($sformatf("warning%0d", i),  8'(wn[i]), 8'(m_mode[i] == M_RUN && m_rem[i] <= WARN));
      chk($sformatf("tens%0d", i),     8'(tens[i]), 8'(m_rem[i] / 10));
      chk($sformatf("ones%0d", i),     8'(ones[i]), 8'(m_rem[i] % 10));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // called at posedge+1: async reset pulse released before the next edge
  task automatic reset_pulse();
    resetN = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    resetN = 1'b1;
  endtask

  task automatic start_game();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    int cnt;
    int first;
    bit found;

    // reset state
    #2 resetN = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_tens", 8'(tens[0]), 8'd0);
    chk("rst_ones", 8'(ones[0]), 8'd3);
    chk("rst_pulse", 8'(p[0]), 8'd0);
    #1 resetN = 1'b1;

    // idle: prescaler free-runs
    cnt = 0;
    for (int k = 0; k < 35; k++) begin
      step();
      if (p[0]) cnt++;
    end
    chk("idle_pulses", 8'(cnt), 8'd3);
    chk("idle_running", 8'(rn[0]), 8'd0);

    // full countdown 03 -> 00
    start_game();
    for (int k = 1; k <= 31; k++) begin
      step();
      if (k == 10) begin
        chk("cd_k10_ones", 8'(ones[0]), 8'd3);
        chk("cd_k10_warn", 8'(wn[0]), 8'd0);
      end
      if (k == 11) begin
        chk("cd_k11_ones", 8'(ones[0]), 8'd2);
        chk("cd_k11_warn", 8'(wn[0]), 8'd1);
        chk("borrow_tens", 8'(tens[1]), 8'd1);
        chk("borrow_ones", 8'(ones[1]), 8'd9);
      end
      if (k == 21) chk("cd_k21_ones", 8'(ones[0]), 8'd1);
      if (k == 30) chk("cd_k30_te", 8'(te[0]), 8'd0);
    end
    chk("cd_end_te", 8'(te[0]), 8'd1);
    chk("cd_end_ones", 8'(ones[0]), 8'd0);
    steps(50);
    chk("cd_hold_te", 8'(te[0]), 8'd1);

    // freeze on the same cycle as the first tick
    reset_pulse();
    start_game();
    found = 1'b0;
    for (int k = 0; k < 3 * N && !found; k++) begin
      step();
      if (m_pulse[0]) found = 1'b1;
    end
    chk("first_tick_seen", 8'(found), 8'd1);
    freeze = 1'b1;
    step();
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (p[0]) cnt++;
      if (k == 5) freeze = 1'b0;
    end
    freeze = 1'b0;
    chk("frz_ones", 8'(ones[0]), 8'd3);
    chk("frz_running", 8'(rn[0]), 8'd0);
    chk("frz_te", 8'(te[0]), 8'd0);
    chk("frz_pulses", 8'(cnt), 8'd3);

    // bonus on 97 saturates
    reset_pulse();
    start_game();
    steps(2);
    bonus = 1'b1;
    step();
    bonus = 1'b0;
`ifdef TIMER_BONUS_EN
    chk("bonus_sat_tens", 8'(tens[2]), 8'd9);
    chk("bonus_sat_ones", 8'(ones[2]), 8'd9);
`endif
    steps(3);

    // bonus coincident with the 01 -> 00 tick
    reset_pulse();
    start_game();
    found = 1'b0;
    for (int k = 0; k < 6 * N && !found; k++) begin
      step();
      if (m_rem[0] == 1 && m_pulse[0]) found = 1'b1;
    end
    chk("bonus_tick_seen", 8'(found), 8'd1);
    bonus = 1'b1;
    step();
    bonus = 1'b0;
`ifdef TIMER_BONUS_EN
    chk("bonus_exp_ones", 8'(ones[0]), 8'd4);
    chk("bonus_exp_run", 8'(rn[0]), 8'd1);
`else
    chk("nobonus_exp_te", 8'(te[0]), 8'd1);
`endif
    steps(5);

    // asynchronous reset mid-count at value 01
    reset_pulse();
    start_game();
    found = 1'b0;
    for (int k = 0; k < 6 * N && !found; k++) begin
      step();
      if (m_rem[0] == 1) found = 1'b1;
    end
    chk("at01_seen", 8'(found), 8'd1);
    steps(3);
    reset_pulse();
    chk("midrst_ones", 8'(ones[0]), 8'd3);
    chk("midrst_te", 8'(te[0]), 8'd0);
    chk("midrst_run", 8'(rn[0]), 8'd0);
    first = 0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (p[0] && first == 0) first = k;
    end
    chk("midrst_first_pulse", 8'(first), 8'(N));

    // randomized traffic against the model
    for (int k = 0; k < 800; k++) begin
      start  = ($urandom_range(0, 19) == 0);
      freeze = ($urandom_range(0, 59) == 0);
      bonus  = ($urandom_range(0, 7) == 0);
      step();
      if ($urandom_range(0, 149) == 0) begin
        start = 1'b0; freeze = 1'b0; bonus = 1'b0;
        reset_pulse();
      end
    end
    start = 1'b0; freeze = 1'b0; bonus = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
